// File: rtl/digit_rec_pkg.sv
// Shared definitions for the digit-recognition datapath: coordinate width, controller states
// and the default pixel/sync polarities.
package digit_rec_pkg;

    localparam int unsigned CW = 12;

    localparam logic FG_DEFAULT     = 1'b0;
    localparam logic VS_POL_DEFAULT = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StCalc
    } scan_state_e;

    // Evaluated at 32 bits so a zero lower bound never turns into a constant compare.
    function automatic logic in_range(input int unsigned v, input int unsigned lo,
                                      input int unsigned hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/seq_udiv_const3.sv
// Restoring divider by 3: one quotient bit per cycle, CW cycles from start to done.
// start wins over abort so a restart can be issued in the same cycle as the abort.
module seq_udiv_const3
    import digit_rec_pkg::*;
#(
    parameter int unsigned CW = digit_rec_pkg::CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] dividend,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] quotient
);

    localparam int unsigned CNT_W = $clog2(CW);

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CW-1:0]    dvd_q, dvd_d;
    logic [CW-1:0]    quo_q, quo_d;
    logic [1:0]       rem_q, rem_d;
    logic [2:0]       trial;

    always_comb begin
        busy_d = busy_q;
        done_d = 1'b0;
        cnt_d  = cnt_q;
        dvd_d  = dvd_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        trial  = {rem_q, dvd_q[CW-1]};
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            dvd_d  = dividend;
            quo_d  = '0;
            rem_d  = '0;
        end else if (abort) begin
            busy_d = 1'b0;
        end else if (busy_q) begin
            dvd_d = {dvd_q[CW-2:0], 1'b0};
            if (trial >= 3'd3) begin
                rem_d = 2'(trial - 3'd3);
                quo_d = {quo_q[CW-2:0], 1'b1};
            end else begin
                rem_d = trial[1:0];
                quo_d = {quo_q[CW-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(CW - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            dvd_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            dvd_q  <= dvd_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/char_box_scan_ctrl.sv
// Per-frame bounding-box finder: accumulates foreground extents inside the ROI and publishes the
// box plus the 1/3 and 2/3 scan rows atomically CW+2 cycles after each frame edge.
module char_box_scan_ctrl
    import digit_rec_pkg::*;
#(
    parameter int unsigned CW     = digit_rec_pkg::CW,
    parameter logic        FG     = FG_DEFAULT,
    parameter logic        VS_POL = VS_POL_DEFAULT,
    parameter int unsigned ROI_X0 = 0,
    parameter int unsigned ROI_X1 = 479,
    parameter int unsigned ROI_Y0 = 0,
    parameter int unsigned ROI_Y1 = 271,
    parameter int unsigned MIN_W  = 4,
    parameter int unsigned MIN_H  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    input  logic          i_vs,
    input  logic          i_de,
    input  logic          i_th,
    output logic [CW-1:0] char_up,
    output logic [CW-1:0] char_down,
    output logic [CW-1:0] char_left,
    output logic [CW-1:0] char_right,
    output logic [CW-1:0] row_scanf_line1,
    output logic [CW-1:0] row_scanf_line2,
    output logic          box_valid,
    output logic          box_upd,
    output logic          calc_ovr
);

    scan_state_e state_q, state_d;

    logic vs_q;
    logic frame_edge;

    logic [CW-1:0] min_x_q, min_x_d, max_x_q, max_x_d;
    logic [CW-1:0] min_y_q, min_y_d, max_y_q, max_y_d;
    logic          found_q, found_d;

    logic [CW-1:0] snap_min_x_q, snap_max_x_q, snap_min_y_q, snap_max_y_q;
    logic          snap_found_q;

    logic [CW-1:0] up_q, down_q, left_q, right_q, line1_q, line2_q;
    logic          box_valid_q, box_upd_q, calc_ovr_q;

    logic          pix_ok, acc_en, acc_clr, snap_en, write_en, ovr_set;
    logic          div_start, div_abort, div_busy, div_done;
    logic [CW-1:0] div_quotient;
    logic [CW-1:0] snap_w, snap_h;
    logic          frame_valid;

    assign frame_edge = (i_vs == VS_POL) && (vs_q != VS_POL);

    assign pix_ok = i_de && (i_th == FG)
                    && in_range(32'(x), ROI_X0, ROI_X1)
                    && in_range(32'(y), ROI_Y0, ROI_Y1);

    // A pixel coincident with the edge belongs to the frame that is just starting.
    assign acc_en = (state_q != StIdle) || frame_edge;

    always_comb begin
        state_d   = state_q;
        acc_clr   = 1'b0;
        snap_en   = 1'b0;
        div_start = 1'b0;
        div_abort = 1'b0;
        write_en  = 1'b0;
        ovr_set   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (frame_edge) begin
                    acc_clr = 1'b1;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (frame_edge) begin
                    acc_clr   = 1'b1;
                    snap_en   = 1'b1;
                    div_start = 1'b1;
                    state_d   = StCalc;
                end
            end
            StCalc: begin
                if (frame_edge) begin
                    acc_clr   = 1'b1;
                    snap_en   = 1'b1;
                    div_start = 1'b1;
                    div_abort = 1'b1;
                    ovr_set   = 1'b1;
                end else if (div_done && !div_busy) begin
                    write_en = 1'b1;
                    state_d  = StScan;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        min_x_d = acc_clr ? '1 : min_x_q;
        max_x_d = acc_clr ? '0 : max_x_q;
        min_y_d = acc_clr ? '1 : min_y_q;
        max_y_d = acc_clr ? '0 : max_y_q;
        found_d = acc_clr ? 1'b0 : found_q;
        if (pix_ok && acc_en) begin
            if (x < min_x_d) min_x_d = x;
            if (x > max_x_d) max_x_d = x;
            if (y < min_y_d) min_y_d = y;
            if (y > max_y_d) max_y_d = y;
            found_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            vs_q    <= ~VS_POL;
            min_x_q <= '1;
            max_x_q <= '0;
            min_y_q <= '1;
            max_y_q <= '0;
            found_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vs_q    <= i_vs;
            min_x_q <= min_x_d;
            max_x_q <= max_x_d;
            min_y_q <= min_y_d;
            max_y_q <= max_y_d;
            found_q <= found_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_min_x_q <= '0;
            snap_max_x_q <= '0;
            snap_min_y_q <= '0;
            snap_max_y_q <= '0;
            snap_found_q <= 1'b0;
        end else if (snap_en) begin
            snap_min_x_q <= min_x_q;
            snap_max_x_q <= max_x_q;
            snap_min_y_q <= min_y_q;
            snap_max_y_q <= max_y_q;
            snap_found_q <= found_q;
        end
    end

    seq_udiv_const3 #(
        .CW(CW)
    ) u_div3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (div_start),
        .dividend(max_y_q - min_y_q),
        .abort   (div_abort),
        .busy    (div_busy),
        .done    (div_done),
        .quotient(div_quotient)
    );

    assign snap_w      = snap_max_x_q - snap_min_x_q;
    assign snap_h      = snap_max_y_q - snap_min_y_q;
    assign frame_valid = snap_found_q && (snap_w >= CW'(MIN_W)) && (snap_h >= CW'(MIN_H));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_q        <= '0;
            down_q      <= '0;
            left_q      <= '0;
            right_q     <= '0;
            line1_q     <= '0;
            line2_q     <= '0;
            box_valid_q <= 1'b0;
            box_upd_q   <= 1'b0;
            calc_ovr_q  <= 1'b0;
        end else begin
            box_upd_q  <= write_en;
            calc_ovr_q <= ovr_set;
            if (write_en) begin
                box_valid_q <= frame_valid;
                if (frame_valid) begin
                    up_q    <= snap_min_y_q;
                    down_q  <= snap_max_y_q;
                    left_q  <= snap_min_x_q;
                    right_q <= snap_max_x_q;
                    line1_q <= snap_min_y_q + div_quotient;
                    line2_q <= snap_max_y_q - div_quotient;
                end
            end
        end
    end

    assign char_up         = up_q;
    assign char_down       = down_q;
    assign char_left       = left_q;
    assign char_right      = right_q;
    assign row_scanf_line1 = line1_q;
    assign row_scanf_line2 = line2_q;
    assign box_valid       = box_valid_q;
    assign box_upd         = box_upd_q;
    assign calc_ovr        = calc_ovr_q;

endmodule

// File: tb/tb_char_box_scan_ctrl.sv
// Bench for char_box_scan_ctrl: 64x48 frames, one DUT with full ROI and one with ROI_X0=10,
// both checked against a frame-level bounding-box model.
module tb_char_box_scan_ctrl;

    localparam int W = 64;
    localparam int H = 48;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] x = '0, y = '0;
    logic        i_vs = 1'b0, i_de = 1'b0, i_th = 1'b1;

    logic [11:0] up[2], down[2], left[2], right[2], l1[2], l2[2];
    logic        bv[2], bu[2], ov[2];

    int checks = 0;
    int errors = 0;

    bit          fg[H][W];
    logic [11:0] m_out[2][6];
    logic        m_valid[2];

    always #5 clk = ~clk;

    char_box_scan_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .i_vs(i_vs), .i_de(i_de), .i_th(i_th),
        .char_up(up[0]), .char_down(down[0]), .char_left(left[0]), .char_right(right[0]),
        .row_scanf_line1(l1[0]), .row_scanf_line2(l2[0]),
        .box_valid(bv[0]), .box_upd(bu[0]), .calc_ovr(ov[0])
    );

    char_box_scan_ctrl #(.ROI_X0(10)) u_dut_roi (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .i_vs(i_vs), .i_de(i_de), .i_th(i_th),
        .char_up(up[1]), .char_down(down[1]), .char_left(left[1]), .char_right(right[1]),
        .row_scanf_line1(l1[1]), .row_scanf_line2(l2[1]),
        .box_valid(bv[1]), .box_upd(bu[1]), .calc_ovr(ov[1])
    );

    function automatic logic [11:0] dut_out(input int d, input int k);
        case (k)
            0:       return up[d];
            1:       return down[d];
            2:       return left[d];
            3:       return right[d];
            4:       return l1[d];
            default: return l2[d];
        endcase
    endfunction

    task automatic clear_fg();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) fg[r][c] = 1'b0;
    endtask

    task automatic add_rect(input int x0, input int x1, input int y0, input int y1);
        for (int r = y0; r <= y1; r++) for (int c = x0; c <= x1; c++) fg[r][c] = 1'b1;
    endtask

    // Reference: box of the foreground pixels of fg[] inside each DUT's ROI.
    task automatic model_publish();
        for (int d = 0; d < 2; d++) begin
            int  lo_x;
            int  mnx, mxx, mny, mxy, h;
            bit  found, valid;
            lo_x  = (d == 1) ? 10 : 0;
            mnx   = 4095; mxx = 0; mny = 4095; mxy = 0; found = 0;
            for (int r = 0; r < H; r++)
                for (int c = lo_x; c < W; c++)
                    if (fg[r][c]) begin
                        found = 1;
                        if (c < mnx) mnx = c;
                        if (c > mxx) mxx = c;
                        if (r < mny) mny = r;
                        if (r > mxy) mxy = r;
                    end
            h     = mxy - mny;
            valid = found && (mxx - mnx >= 4) && (h >= 8);
            if (valid) begin
                m_out[d][0] = 12'(mny);
                m_out[d][1] = 12'(mxy);
                m_out[d][2] = 12'(mnx);
                m_out[d][3] = 12'(mxx);
                m_out[d][4] = 12'(mny + h / 3);
                m_out[d][5] = 12'(mxy - h / 3);
            end
            m_valid[d] = valid;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 6; k++) m_out[d][k] = '0;
            m_valid[d] = 1'b0;
        end
    endtask

    // Drives the active area row by row; n_pix >= 0 stops after that many active pixels.
    task automatic drive_frame(input int n_pix);
        int n = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (n_pix >= 0 && n >= n_pix) return;
                @(posedge clk); #1;
                i_de = 1'b1; x = 12'(c); y = 12'(r);
                i_th = fg[r][c] ? 1'b0 : 1'b1;
                n++;
            end
            repeat (2) begin
                @(posedge clk); #1;
                i_de = 1'b0; i_th = 1'b0;
                x = 12'($urandom_range(0, W - 1)); y = 12'($urandom_range(0, H - 1));
            end
        end
        @(posedge clk); #1;
        i_de = 1'b0; i_th = 1'b1;
    endtask

    // Raises i_vs at t=0 (optionally again at second_at) and watches 40 cycles.
    task automatic do_edge(input int second_at, output int upd_t, output int upd_n,
                           output int upd1_n, output int ovr_n);
        upd_t = -1; upd_n = 0; upd1_n = 0; ovr_n = 0;
        @(posedge clk); #1;
        i_de = 1'b0; i_vs = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            @(posedge clk); #1;
            if (bu[0] === 1'b1) begin upd_n++; upd_t = t; end
            if (bu[1] === 1'b1) upd1_n++;
            if (ov[0] === 1'b1) ovr_n++;
            if (t == 3) i_vs = 1'b0;
            if (second_at > 0 && t == second_at) i_vs = 1'b1;
            if (second_at > 0 && t == second_at + 3) i_vs = 1'b0;
            i_th = 1'($urandom_range(0, 1));
        end
        i_vs = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (dut_out(d, k) !== 12'd0) begin
                    errors++;
                    $display("FAIL reset_coord d%0d k%0d: got %0d want 0", d, k, dut_out(d, k));
                end
            end
            checks++;
            if ({bv[d], bu[d], ov[d]} !== 3'b000) begin
                errors++;
                $display("FAIL reset_flags d%0d: got %b want 000", d, {bv[d], bu[d], ov[d]});
            end
        end
        rst_n = 1'b1;
        model_reset();
        begin
            int ut, un, u1, on;
            do_edge(-1, ut, un, u1, on);
            checks++;
            if (un !== 0 || u1 !== 0) begin
                errors++;
                $display("FAIL reset_first_edge: got %0d/%0d pulses want 0", un, u1);
            end
        end
    endtask

    // Publishes fg[] with an edge and checks timing plus all outputs of both DUTs.
    task automatic test_frame(input string name);
        int ut, un, u1, on;
        drive_frame(-1);
        do_edge(-1, ut, un, u1, on);
        model_publish();
        checks++;
        if (un !== 1 || u1 !== 1 || ut !== 14) begin
            errors++;
            $display("FAIL %s_upd: got %0d/%0d pulses last at t=%0d want 1/1 at 14",
                     name, un, u1, ut);
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (bv[d] !== m_valid[d]) begin
                errors++;
                $display("FAIL %s_valid d%0d: got %b want %b", name, d, bv[d], m_valid[d]);
            end
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (dut_out(d, k) !== m_out[d][k]) begin
                    errors++;
                    $display("FAIL %s_coord d%0d k%0d: got %0d want %0d",
                             name, d, k, dut_out(d, k), m_out[d][k]);
                end
            end
        end
    endtask

    task automatic test_rect();
        clear_fg();
        add_rect(20, 39, 10, 39);
        test_frame("rect");
        checks++;
        if ({up[0], down[0], left[0], right[0], l1[0], l2[0]} !==
            {12'd10, 12'd39, 12'd20, 12'd39, 12'd19, 12'd30} || bv[0] !== 1'b1) begin
            errors++;
            $display("FAIL rect_const: got %0d %0d %0d %0d %0d %0d v=%b want 10 39 20 39 19 30 v=1",
                     up[0], down[0], left[0], right[0], l1[0], l2[0], bv[0]);
        end
    endtask

    task automatic test_roi();
        clear_fg();
        add_rect(20, 39, 10, 39);
        fg[2][2] = 1'b1;
        test_frame("roi");
        checks++;
        if ({up[1], down[1], left[1], right[1], l1[1], l2[1]} !==
            {12'd10, 12'd39, 12'd20, 12'd39, 12'd19, 12'd30}) begin
            errors++;
            $display("FAIL roi_const: got %0d %0d %0d %0d %0d %0d want 10 39 20 39 19 30",
                     up[1], down[1], left[1], right[1], l1[1], l2[1]);
        end
    endtask

    task automatic test_background();
        clear_fg();
        test_frame("bg");
    endtask

    task automatic test_single_px();
        clear_fg();
        fg[5][5] = 1'b1;
        test_frame("single");
    endtask

    task automatic test_random_frames(input int n);
        for (int i = 0; i < n; i++) begin
            int x0, y0;
            clear_fg();
            x0 = $urandom_range(0, 50);
            y0 = $urandom_range(0, 35);
            add_rect(x0, x0 + $urandom_range(0, 13), y0, y0 + $urandom_range(3, 12));
            repeat ($urandom_range(0, 3))
                fg[$urandom_range(0, H - 1)][$urandom_range(0, W - 1)] = 1'b1;
            test_frame("rand");
        end
    endtask

    task automatic test_calc_ovr();
        int ut, un, u1, on;
        clear_fg();
        add_rect(12, 50, 4, 44);
        drive_frame(-1);
        do_edge(6, ut, un, u1, on);
        // The rectangle frame is aborted; only the empty 6-cycle frame gets published.
        clear_fg();
        model_publish();
        checks++;
        if (on !== 1) begin
            errors++;
            $display("FAIL ovr_pulse: got %0d pulses want 1", on);
        end
        checks++;
        if (un !== 1 || u1 !== 1 || ut !== 20) begin
            errors++;
            $display("FAIL ovr_upd: got %0d/%0d pulses last at t=%0d want 1/1 at 20", un, u1, ut);
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (bv[d] !== m_valid[d]) begin
                errors++;
                $display("FAIL ovr_valid d%0d: got %b want %b", d, bv[d], m_valid[d]);
            end
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (dut_out(d, k) !== m_out[d][k]) begin
                    errors++;
                    $display("FAIL ovr_coord d%0d k%0d: got %0d want %0d",
                             d, k, dut_out(d, k), m_out[d][k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int ut, un, u1, on;
        clear_fg();
        add_rect(5, 30, 5, 30);
        drive_frame(1500);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({up[d], down[d], left[d], right[d], l1[d], l2[d], bv[d], bu[d], ov[d]} !== '0)
            begin
                errors++;
                $display("FAIL midrst_zero d%0d: got %0d %0d %0d %0d %0d %0d %b%b%b want all 0",
                         d, up[d], down[d], left[d], right[d], l1[d], l2[d], bv[d], bu[d], ov[d]);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        i_de = 1'b0;
        rst_n = 1'b1;
        model_reset();
        do_edge(-1, ut, un, u1, on);
        checks++;
        if (un !== 0 || u1 !== 0) begin
            errors++;
            $display("FAIL midrst_first_edge: got %0d/%0d pulses want 0", un, u1);
        end
        clear_fg();
        add_rect(15, 45, 8, 40);
        test_frame("midrst");
    endtask

    initial begin
        model_reset();
        clear_fg();
        test_reset();
        test_rect();
        test_roi();
        test_background();
        test_single_px();
        test_random_frames(5);
        test_calc_ovr();
        test_rect();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
